// File: rtl/mul_div_unit.sv
// Sequential signed multiply/divide engine: Booth radix-2 multiply and non-restoring
// divide, one iteration per clock, producing a 2*WIDTH-bit result for the Z register.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] Zhigh,
  output logic [WIDTH-1:0] Zlow
);

  localparam int AW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             op_q, op_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic             dbz_pend_q, dbz_pend_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] zhi_q, zhi_d;
  logic [WIDTH-1:0] zlo_q, zlo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [AW-1:0]    m_ext, d_ext;
  logic [AW-1:0]    booth_sum, mul_acc_n;
  logic [WIDTH-1:0] mul_lo_n;
  logic [AW-1:0]    div_sh, div_r_n;
  logic [WIDTH-1:0] div_lo_n, rem_mag;
  logic [WIDTH-1:0] div_quot, div_rem;

  // One radix-2 step of each algorithm, plus the divide sign fix-up for the final step.
  always_comb begin
    a_mag = a_in[WIDTH-1] ? -a_in : a_in;
    b_mag = b_in[WIDTH-1] ? -b_in : b_in;
    m_ext = {{2{m_q[WIDTH-1]}}, m_q};
    d_ext = {2'b00, m_q};

    booth_sum = acc_q;
    case ({lo_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase
    mul_acc_n = {booth_sum[AW-1], booth_sum[AW-1:1]};
    mul_lo_n  = {booth_sum[0], lo_q[WIDTH-1:1]};

    div_sh   = {acc_q[WIDTH:0], lo_q[WIDTH-1]};
    div_r_n  = acc_q[AW-1] ? (div_sh + d_ext) : (div_sh - d_ext);
    div_lo_n = {lo_q[WIDTH-2:0], ~div_r_n[AW-1]};

    // Final remainder lies in [0, divisor) once corrected, so WIDTH bits suffice.
    rem_mag  = div_r_n[AW-1] ? (div_r_n[WIDTH-1:0] + m_q) : div_r_n[WIDTH-1:0];
    div_quot = (a_neg_q ^ b_neg_q) ? -div_lo_n : div_lo_n;
    div_rem  = a_neg_q ? -rem_mag : rem_mag;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_neg_d    = a_neg_q;
    b_neg_d    = b_neg_q;
    dbz_pend_d = dbz_pend_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    lo_d       = lo_q;
    qm1_d      = qm1_q;
    m_d        = m_q;
    zhi_d      = zhi_q;
    zlo_d      = zlo_q;
    dbz_d      = dbz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_RUN;
          op_d       = op;
          a_neg_d    = op & a_in[WIDTH-1];
          b_neg_d    = op & b_in[WIDTH-1];
          dbz_pend_d = op && (b_in == '0);
          cnt_d      = '0;
          acc_d      = '0;
          qm1_d      = 1'b0;
          dbz_d      = 1'b0;
          if (op) begin
            m_d  = b_mag;
            // A zero divisor skips iterations; keep the raw dividend for Zhigh.
            lo_d = (b_in == '0) ? a_in : a_mag;
          end else begin
            m_d  = a_in;
            lo_d = b_in;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (dbz_pend_q) begin
          state_d    = S_DONE;
          zhi_d      = lo_q;
          zlo_d      = '1;
          dbz_d      = 1'b1;
          dbz_pend_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (op_q) begin
            acc_d = div_r_n;
            lo_d  = div_lo_n;
          end else begin
            acc_d = mul_acc_n;
            lo_d  = mul_lo_n;
            qm1_d = lo_q[0];
          end
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = S_DONE;
            dbz_d   = 1'b0;
            if (op_q) begin
              zhi_d = div_rem;
              zlo_d = div_quot;
            end else begin
              zhi_d = mul_acc_n[WIDTH-1:0];
              zlo_d = mul_lo_n;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q    <= S_IDLE;
      op_q       <= 1'b0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      dbz_pend_q <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      lo_q       <= '0;
      qm1_q      <= 1'b0;
      m_q        <= '0;
      zhi_q      <= '0;
      zlo_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_neg_q    <= a_neg_d;
      b_neg_q    <= b_neg_d;
      dbz_pend_q <= dbz_pend_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      lo_q       <= lo_d;
      qm1_q      <= qm1_d;
      m_q        <= m_d;
      zhi_q      <= zhi_d;
      zlo_q      <= zlo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign Zhigh       = zhi_q;
  assign Zlow        = zlo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed products/quotients, latency,
// divide-by-zero, overflow, ignored start, asynchronous clear and back-to-back ops.
module tb_mul_div_unit;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         clear;
  logic         start;
  logic         op;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] Zhigh;
  logic [W-1:0] Zlow;

  int n_checks = 0;
  int n_fail   = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .a_in        (a_in),
    .b_in        (b_in),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .Zhigh       (Zhigh),
    .Zlow        (Zlow)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Issue one op; lat counts edges from the accept edge (inclusive) to the edge raising done.
  task automatic do_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int busy_cnt,
                       output logic dbz_acc, output logic [W-1:0] zlo_acc);
    @(negedge clock);
    start = 1'b1;
    op    = o;
    a_in  = a;
    b_in  = b;
    @(posedge clock);
    #1;
    start = 1'b0;
    op    = ~o;
    a_in  = ~a;
    b_in  = ~b;
    lat      = 1;
    busy_cnt = 0;
    dbz_acc  = div_by_zero;
    zlo_acc  = Zlow;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(posedge clock);
      #1;
      lat++;
    end
    $display("op=%s a=%h b=%h -> Zhigh=%h Zlow=%h dbz=%0d lat=%0d",
             o ? "DIV" : "MUL", a, b, Zhigh, Zlow, div_by_zero, lat);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, bcnt, first_done, n_done;
    logic        dbz_acc;
    logic [W-1:0] zlo_acc;

    clear = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a_in  = '0;
    b_in  = '0;
    idle(2);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    check_eq("rst_z", {Zhigh, Zlow}, 64'd0);
    clear = 1'b0;
    idle(2);

    // MUL 7 x -3
    do_op(1'b0, 32'd7, 32'hFFFF_FFFD, lat, bcnt, dbz_acc, zlo_acc);
    check_eq("mul1_lat", 64'(lat), 64'd33);
    check_eq("mul1_busy", 64'(bcnt), 64'd32);
    check_eq("mul1_z", {Zhigh, Zlow}, 64'hFFFF_FFFF_FFFF_FFEB);
    check_eq("mul1_dbz", {63'd0, div_by_zero}, 64'd0);
    idle(1);
    check_eq("mul1_pulse", {62'd0, done, busy}, 64'd0);
    check_eq("mul1_hold", {Zhigh, Zlow}, 64'hFFFF_FFFF_FFFF_FFEB);
    idle(2);

    do_op(1'b0, 32'h8000_0000, 32'h8000_0000, lat, bcnt, dbz_acc, zlo_acc);
    check_eq("mul_minmin", {Zhigh, Zlow}, 64'h4000_0000_0000_0000);
    idle(2);
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt, dbz_acc, zlo_acc);
    check_eq("mul_m1m1", {Zhigh, Zlow}, 64'h0000_0000_0000_0001);
    idle(2);

    do_op(1'b1, 32'hFFFF_FFEF, 32'd5, lat, bcnt, dbz_acc, zlo_acc);
    check_eq("div_neg17_5", {Zhigh, Zlow}, 64'hFFFF_FFFE_FFFF_FFFD);
    check_eq("div_lat", 64'(lat), 64'd33);
    idle(2);
    do_op(1'b1, 32'd17, 32'hFFFF_FFFB, lat, bcnt, dbz_acc, zlo_acc);
    check_eq("div_17_neg5", {Zhigh, Zlow}, 64'h0000_0002_FFFF_FFFD);
    idle(2);

    // Divide by zero finishes at E1
    do_op(1'b1, 32'd100, 32'd0, lat, bcnt, dbz_acc, zlo_acc);
    check_eq("dbz_lat", 64'(lat), 64'd2);
    check_eq("dbz_busy", 64'(bcnt), 64'd1);
    check_eq("dbz_flag", {63'd0, div_by_zero}, 64'd1);
    check_eq("dbz_z", {Zhigh, Zlow}, 64'h0000_0064_FFFF_FFFF);
    idle(1);
    do_op(1'b0, 32'd3, 32'd4, lat, bcnt, dbz_acc, zlo_acc);
    check_eq("dbz_clr_accept", {63'd0, dbz_acc}, 64'd0);
    check_eq("mul_3_4", {Zhigh, Zlow}, 64'h0000_0000_0000_000C);
    check_eq("mul_3_4_dbz", {63'd0, div_by_zero}, 64'd0);
    idle(2);

    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt, dbz_acc, zlo_acc);
    check_eq("div_ovf_z", {Zhigh, Zlow}, 64'h0000_0000_8000_0000);
    check_eq("div_ovf_dbz", {63'd0, div_by_zero}, 64'd0);
    idle(2);

    // Second start 5 cycles into a MUL must be ignored
    @(negedge clock);
    start = 1'b1; op = 1'b0; a_in = 32'd5; b_in = 32'd6;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    start = 1'b1; op = 1'b1; a_in = 32'd100; b_in = 32'd0;
    @(posedge clock);
    #1;
    start = 1'b0;
    lat = 7;
    first_done = 0;
    n_done = 0;
    while (lat < 50) begin
      if (done) begin
        n_done++;
        if (first_done == 0) first_done = lat;
      end
      @(posedge clock);
      #1;
      lat++;
    end
    $display("op=MUL a=5 b=6 (restart ignored) -> Zhigh=%h Zlow=%h done_at=%0d pulses=%0d",
             Zhigh, Zlow, first_done, n_done);
    check_eq("ign_lat", 64'(first_done), 64'd33);
    check_eq("ign_pulses", 64'(n_done), 64'd1);
    check_eq("ign_z", {Zhigh, Zlow}, 64'h0000_0000_0000_001E);
    check_eq("ign_dbz", {63'd0, div_by_zero}, 64'd0);

    // Asynchronous clear 10 cycles into a DIV
    @(negedge clock);
    start = 1'b1; op = 1'b1; a_in = 32'd1000; b_in = 32'd7;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #3;
    check_eq("pre_clr_busy", {63'd0, busy}, 64'd1);
    clear = 1'b1;
    #1;
    check_eq("clr_busy", {63'd0, busy}, 64'd0);
    check_eq("clr_done", {63'd0, done}, 64'd0);
    check_eq("clr_z", {Zhigh, Zlow}, 64'd0);
    $display("clear asserted mid-DIV -> busy=%0d done=%0d Zhigh=%h Zlow=%h", busy, done, Zhigh, Zlow);
    #2;
    clear = 1'b0;
    idle(3);
    check_eq("post_clr_idle", {62'd0, busy, done}, 64'd0);

    do_op(1'b1, 32'd1000, 32'd7, lat, bcnt, dbz_acc, zlo_acc);
    check_eq("div_after_clr", {Zhigh, Zlow}, 64'h0000_0006_0000_008E);
    check_eq("div_after_clr_lat", 64'(lat), 64'd33);
    idle(2);

    // Back-to-back: the second do_op raises start during the DONE cycle
    do_op(1'b0, 32'd9, 32'd9, lat, bcnt, dbz_acc, zlo_acc);
    check_eq("b2b_first", {Zhigh, Zlow}, 64'h0000_0000_0000_0051);
    do_op(1'b1, 32'hFFFF_FF9C, 32'd7, lat, bcnt, dbz_acc, zlo_acc);
    check_eq("b2b_hold", {32'd0, zlo_acc}, 64'h0000_0000_0000_0051);
    check_eq("b2b_lat", 64'(lat), 64'd33);
    check_eq("b2b_second", {Zhigh, Zlow}, 64'hFFFF_FFFE_FFFF_FFF2);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
